sprite_position_ctrl: RTL

- Owns the on-screen square's bounding box (h_min/h_max/v_min/v_max) that the pixel colour logic compares against hcounter/vcounter.
- Accepts signed move requests through a valid/ready handshake and buffers one of them.
- Applies a buffered move only at the first vertical-blank line, so the box never changes during active video.
- Clamps the box to the visible area and reports which edges it hit.

---
 rtl/sprite_position_ctrl_if.sv | 12 +
 rtl/sprite_position_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sprite_position_ctrl_if.sv
// Move-request channel between a requester and sprite_position_ctrl.
// Latency: none; this is wiring only.
// Backpressure: the requester holds move_valid until it samples move_ready high.
interface sprite_position_ctrl_if;
  logic              move_valid;
  logic signed [5:0] move_dx;
  logic signed [5:0] move_dy;
  logic              move_ready;

  modport master (output move_valid, output move_dx, output move_dy, input move_ready);
  modport slave  (input move_valid, input move_dx, input move_dy, output move_ready);
endinterface

// File: rtl/sprite_position_ctrl.sv
// Owns the square's bounding box; applies one buffered signed move per frame, clamped to the screen.
// Latency: the new box is on the outputs 3 cycles after the frame_start cycle (inside vertical blank).
// Backpressure: a one-entry buffer; move_ready is low from accept until the cycle after COMMIT.
module sprite_position_ctrl #(
  parameter int HLINES = 640,
  parameter int VLINES = 480,
  parameter int SIZE   = 40,
  parameter int INIT_X = 300,
  parameter int INIT_Y = 220
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic [10:0]                 hcounter,
  input  logic [10:0]                 vcounter,
  sprite_position_ctrl_if.slave       move,
  output logic [10:0]                 h_min,
  output logic [10:0]                 h_max,
  output logic [10:0]                 v_min,
  output logic [10:0]                 v_max,
  output logic                        frame_tick,
  output logic                        updated,
  output logic [3:0]                  edge_hit
);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_ADD    = 2'd1;
  localparam logic [1:0] S_CLAMP  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // Largest legal top-left corner so the whole box stays on screen.
  localparam logic signed [11:0] X_LIM = 12'(HLINES - 1 - SIZE);
  localparam logic signed [11:0] Y_LIM = 12'(VLINES - 1 - SIZE);
  localparam logic [10:0]        BOX   = 11'(SIZE);

  logic [1:0]        state;
  logic              pending;
  logic signed [5:0] dx_q;
  logic signed [5:0] dy_q;
  logic signed [11:0] nx;
  logic signed [11:0] ny;
  logic [10:0]       cx;
  logic [10:0]       cy;
  logic [3:0]        hit;
  logic              frame_start;
  logic              accept;

  // Only this exact equality is decoded, so out-of-range counters cannot disturb state.
  assign frame_start     = (hcounter == 11'd0) && (vcounter == 11'(VLINES));
  assign accept          = move.move_valid && !pending;
  assign move.move_ready = !pending;

  // Registered copy of the frame boundary strobe.
  always_ff @(posedge pixel_clk) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= frame_start;
  end

  // One-entry move buffer: fill on accept, release when the commit cycle finishes.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pending <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else if (accept) begin
      pending <= 1'b1;
      dx_q    <= move.move_dx;
      dy_q    <= move.move_dy;
    end else if (state == S_COMMIT) begin
      pending <= 1'b0;
    end
  end

  // Update sequencer; pending is the registered flag, so a same-cycle accept waits a frame.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state <= S_WAIT;
      nx    <= '0;
      ny    <= '0;
    end else begin
      case (state)
        S_WAIT: if (frame_start && pending) state <= S_ADD;
        S_ADD: begin
          nx    <= $signed({1'b0, h_min}) + $signed({{6{dx_q[5]}}, dx_q});
          ny    <= $signed({1'b0, v_min}) + $signed({{6{dy_q[5]}}, dy_q});
          state <= S_CLAMP;
        end
        S_CLAMP:  state <= S_COMMIT;
        S_COMMIT: state <= S_WAIT;
        default:  state <= S_WAIT;
      endcase
    end
  end

  // Clamp the raw sum to the visible area; hit is {bottom, top, right, left}.
  always_comb begin
    cx  = nx[10:0];
    cy  = ny[10:0];
    hit = 4'b0000;
    if (nx < 12'sd0) begin
      cx     = 11'd0;
      hit[0] = 1'b1;
    end else if (nx > X_LIM) begin
      cx     = X_LIM[10:0];
      hit[1] = 1'b1;
    end
    if (ny < 12'sd0) begin
      cy     = 11'd0;
      hit[2] = 1'b1;
    end else if (ny > Y_LIM) begin
      cy     = Y_LIM[10:0];
      hit[3] = 1'b1;
    end
  end

  // Box registers load on the edge entering COMMIT so the new box appears 3 cycles after
  // frame_start; COMMIT itself then frees the buffer.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      h_min    <= 11'(INIT_X);
      h_max    <= 11'(INIT_X + SIZE);
      v_min    <= 11'(INIT_Y);
      v_max    <= 11'(INIT_Y + SIZE);
      updated  <= 1'b0;
      edge_hit <= 4'b0000;
    end else begin
      updated <= 1'b0;
      if (state == S_CLAMP) begin
        h_min    <= cx;
        h_max    <= cx + BOX;
        v_min    <= cy;
        v_max    <= cy + BOX;
        edge_hit <= hit;
        updated  <= 1'b1;
      end
    end
  end

endmodule
